// File: rtl/rggen_bit_field_w1s_req_if.sv
// Register-bus view of one bit field: the decoded access plus the data the field returns.
interface rggen_bit_field_w1s_req_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport slave (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_w1s_req.sv
// Write-1-to-set request field: software sets per-bit requests, hardware clears them with i_ack.
// Optional sticky overrun flags are built when RGGEN_BIT_FIELD_W1S_REQ_OVERRUN_EN is defined.
module rggen_bit_field_w1s_req #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  rggen_bit_field_w1s_req_if.slave   bit_field_if,
  input  logic [WIDTH-1:0]           i_ack,
  output logic [WIDTH-1:0]           o_request,
  output logic [WIDTH-1:0]           o_trigger,
  output logic [WIDTH-1:0]           o_overrun
);
  logic             write_access_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] pending_next_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] trigger_r;

  // Set wins over ack on the same bit, so a re-request is never lost.
  always_comb begin
    write_access_s = bit_field_if.valid && (|bit_field_if.write_mask);
    set_s          = {WIDTH{write_access_s}} & bit_field_if.write_mask & bit_field_if.write_data;
    pending_next_s = (pending_r & ~i_ack) | set_s;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_r <= INITIAL_VALUE;
      trigger_r <= {WIDTH{1'b0}};
    end else begin
      pending_r <= pending_next_s;
      trigger_r <= set_s;
    end
  end

`ifdef RGGEN_BIT_FIELD_W1S_REQ_OVERRUN_EN
  logic             read_access_s;
  logic [WIDTH-1:0] overrun_next_s;
  logic [WIDTH-1:0] overrun_r;

  // A new overrun beats the clearing read in the same cycle.
  always_comb begin
    read_access_s = bit_field_if.valid && (|bit_field_if.read_mask);
    if (read_access_s) begin
      overrun_next_s = set_s & pending_r & ~i_ack;
    end else begin
      overrun_next_s = overrun_r | (set_s & pending_r & ~i_ack);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_r <= {WIDTH{1'b0}};
    end else begin
      overrun_r <= overrun_next_s;
    end
  end

  assign o_overrun = overrun_r;
`else
  assign o_overrun = {WIDTH{1'b0}};
`endif

  assign o_request              = pending_r;
  assign o_trigger              = trigger_r;
  assign bit_field_if.read_data = pending_r;
  assign bit_field_if.value     = pending_r;
endmodule
